// File: rtl/scan_pkg.sv
// Shared definitions for the mux scan controller: FSM state encoding,
// channel count and the display-enable decode.
package scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONT = 2'd1,
      ST_ONE  = 2'd2
   } state_e;

   localparam int         NUM_CH = 4;
   localparam logic [3:0] AN_OFF = 4'b1111;

   // Active-low one-hot enable for the selected channel.
   function automatic logic [3:0] an_decode(input logic [1:0] sel);
      return ~(4'b0001 << sel);
   endfunction

endpackage

// File: rtl/tick_div.sv
// Per-channel dwell counter: counts 0..DIV-1 while enabled and strobes tc
// on the last cycle, which is the cycle the mux output is sampled.
module tick_div #(
   parameter int DIV = 4,
   parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          tc
);

   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, otherwise wrap at LAST while enabled.
   // NOTE: combinational blocks use blocking '=' and assign a default first,
   // so every path drives cnt_d and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   // NOTE: sequential state is updated only with non-blocking '<=' so all
   // flops see pre-edge values regardless of evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = en && (cnt_q == LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer around a 4-to-1 mux: steps the select, lets each channel
// settle for DIV-1 cycles, samples it on the DIV-th, and publishes a full
// {ch3,ch2,ch1,ch0} frame with a one-cycle valid pulse. Also drives the
// active-low digit enables. Runs continuously (en) or for one frame (start).
module mux_scan_ctrl
   import scan_pkg::*;
#(
   parameter int DIV   = 4,
   parameter int WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      start,
   input  logic [WIDTH-1:0]          f_in,
   output logic [1:0]                sel,
   output logic [3:0]                an,
   output logic [NUM_CH*WIDTH-1:0]   frame,
   output logic                      frame_valid,
   output logic                      busy
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   state_e                          state_q, state_d;
   logic [1:0]                      sel_q, sel_d;
   logic [NUM_CH-2:0][WIDTH-1:0]    slot_q, slot_d;
   logic [NUM_CH*WIDTH-1:0]         frame_q, frame_d;
   logic                            frame_valid_q, frame_valid_d;

   logic                            scan_go;
   logic                            tc;
   logic [CW-1:0]                   cnt;
   logic                            unused_cnt;

   // The divider runs only while a scan is live this cycle; in IDLE and on
   // the cycle CONT is abandoned it is held at zero so the next scan starts
   // cleanly at cnt=0.
   assign scan_go = (state_q == ST_ONE) || ((state_q == ST_CONT) && en);

   tick_div #(
      .DIV (DIV),
      .CW  (CW)
   ) u_tick_div (
      .clk (clk),
      .rst (rst),
      .clr (!scan_go),
      .en  (scan_go),
      .cnt (cnt),
      .tc  (tc)
   );

   // The count itself is not needed here; sampling keys off tc alone.
   assign unused_cnt = ^cnt;

   // Next-state: sampling/publishing on tc, then mode transitions.
   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      slot_d        = slot_q;
      frame_d       = frame_q;
      frame_valid_d = 1'b0;

      // Last dwell cycle of a channel: capture it and advance the select.
      // Channel 3 is not stored; it goes straight into the published frame.
      if (tc) begin
         sel_d = sel_q + 2'd1;
         case (sel_q)
            2'd0: slot_d[0] = f_in;
            2'd1: slot_d[1] = f_in;
            2'd2: slot_d[2] = f_in;
            default: begin
               frame_d       = {f_in, slot_q};
               frame_valid_d = 1'b1;
            end
         endcase
      end

      unique case (state_q)
         ST_IDLE: begin
            sel_d = '0;
            if (en) begin
               state_d = ST_CONT;
            end else if (start) begin
               state_d = ST_ONE;
            end
         end
         ST_CONT: begin
            // Dropping en abandons the partial frame; frame keeps its value.
            if (!en) begin
               state_d = ST_IDLE;
               sel_d   = '0;
            end
         end
         ST_ONE: begin
            if (tc && (sel_q == 2'd3)) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = '0;
         end
      endcase
   end

   // All controller state, registered with synchronous reset.
   // NOTE: the channel slots are reset along with the control state because
   // they are few and a reset must leave every frame bit defined.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         sel_q         <= '0;
         slot_q        <= '0;
         frame_q       <= '0;
         frame_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         slot_q        <= slot_d;
         frame_q       <= frame_d;
         frame_valid_q <= frame_valid_d;
      end
   end

   assign sel         = sel_q;
   assign frame       = frame_q;
   assign frame_valid = frame_valid_q;
   assign busy        = (state_q != ST_IDLE);
   assign an          = busy ? an_decode(sel_q) : AN_OFF;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (DIV=4 and DIV=2) share the control
// inputs and each sees its own 4:1 mux of the same data words. A
// time-in-scan model predicts every output cycle by cycle.
module tb_mux_scan_ctrl;

   localparam int DIV_A = 4;
   localparam int DIV_B = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             start;
   logic [3:0][3:0]  data;      // data[0]=a .. data[3]=d

   logic [1:0]  sel4, sel2;
   logic [3:0]  an4, an2;
   logic [15:0] frame4, frame2;
   logic        fv4, fv2, busy4, busy2;
   logic [3:0]  f4, f2;

   assign f4 = data[sel4];
   assign f2 = data[sel2];

   always #5 clk = ~clk;

   mux_scan_ctrl #(.DIV(DIV_A), .WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .en(en), .start(start), .f_in(f4),
      .sel(sel4), .an(an4), .frame(frame4), .frame_valid(fv4), .busy(busy4)
   );

   mux_scan_ctrl #(.DIV(DIV_B), .WIDTH(4)) u_dut2 (
      .clk(clk), .rst(rst), .en(en), .start(start), .f_in(f2),
      .sel(sel2), .an(an2), .frame(frame2), .frame_valid(fv2), .busy(busy2)
   );

   wire [23:0] act4 = {sel4, an4, busy4, fv4, frame4};
   wire [23:0] act2 = {sel2, an2, busy2, fv2, frame2};

   localparam logic [23:0] RESET_VEC = {2'd0, 4'hF, 1'b0, 1'b0, 16'h0000};

   // Model: mode 0=idle, 1=continuous, 2=single; t = cycles since scan entry.
   // The channel being looked at is (t/div)%4 and it is sampled when
   // t%div == div-1.
   typedef struct {
      int              mode;
      int              t;
      logic [3:0][3:0] samp;
      logic [15:0]     frame;
      logic            valid;
   } model_t;

   model_t m4, m2;
   int errors = 0;
   int checks = 0;

   task automatic model_step(input int div, inout model_t m);
      int ch;
      m.valid = 1'b0;
      if (rst) begin
         m.mode  = 0;
         m.t     = 0;
         m.samp  = '0;
         m.frame = '0;
      end else if (m.mode == 0) begin
         if (en) begin
            m.mode = 1; m.t = 0;
         end else if (start) begin
            m.mode = 2; m.t = 0;
         end
      end else if (m.mode == 1 && !en) begin
         m.mode = 0;
      end else begin
         ch = (m.t / div) % 4;
         if (m.t % div == div - 1) begin
            m.samp[ch] = data[ch];
            if (ch == 3) begin
               m.frame = m.samp;
               m.valid = 1'b1;
               if (m.mode == 2) m.mode = 0;
            end
         end
         m.t++;
      end
   endtask

   function automatic logic [23:0] expect_vec(input int div, input model_t m);
      logic [1:0] s;
      logic [3:0] a;
      s = (m.mode == 0) ? 2'd0 : 2'((m.t / div) % 4);
      a = (m.mode == 0) ? 4'hF : ~(4'b0001 << s);
      return {s, a, (m.mode != 0), m.valid, m.frame};
   endfunction

   initial begin
      m4 = '{mode: 0, t: 0, samp: '0, frame: '0, valid: 1'b0};
      m2 = '{mode: 0, t: 0, samp: '0, frame: '0, valid: 1'b0};
   end

   always @(posedge clk) begin
      model_step(DIV_A, m4);
      model_step(DIV_B, m2);
   end

   // One clock: inputs were set at a falling edge, outputs are read at the
   // next falling edge.
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; start = 1'b0; data = '0;
      cycle(); cycle();
      checks++;
      if (act4 !== RESET_VEC) begin
         errors++; $display("FAIL reset_div4: got %h want %h", act4, RESET_VEC);
      end
      checks++;
      if (act2 !== RESET_VEC) begin
         errors++; $display("FAIL reset_div2: got %h want %h", act2, RESET_VEC);
      end
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      int pulses = 0;
      data = {4'd4, 4'd3, 4'd2, 4'd1};
      en = 1'b1;
      repeat (9) begin
         cycle();
         checks++;
         if (act4 !== expect_vec(DIV_A, m4)) begin
            errors++; $display("FAIL mid_frame_run: got %h want %h", act4, expect_vec(DIV_A, m4));
         end
      end
      rst = 1'b1;
      cycle();
      checks++;
      if (act4 !== RESET_VEC) begin
         errors++; $display("FAIL mid_frame_reset: got %h want %h", act4, RESET_VEC);
      end
      rst = 1'b0; en = 1'b0;
      repeat (20) begin
         cycle();
         if (fv4) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++; $display("FAIL mid_frame_no_pulse: got %0d pulses want 0", pulses);
      end
   endtask

   task automatic test_single_frame();
      data = {4'd4, 4'd3, 4'd2, 4'd1};
      start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         start = 1'b0;
         checks++;
         if (act4 !== expect_vec(DIV_A, m4)) begin
            errors++; $display("FAIL single_model cyc%0d: got %h want %h", i, act4, expect_vec(DIV_A, m4));
         end
         if (i <= 16) begin
            checks++;
            if (sel4 !== 2'((i - 1) / 4)) begin
               errors++; $display("FAIL single_sel cyc%0d: got %0d want %0d", i, sel4, (i - 1) / 4);
            end
         end
         if (i == 17) begin
            checks++;
            if ({fv4, busy4, sel4, frame4} !== {1'b1, 1'b0, 2'd0, 16'h4321}) begin
               errors++; $display("FAIL single_publish: got fv=%b busy=%b sel=%0d frame=%h want 1 0 0 4321",
                                  fv4, busy4, sel4, frame4);
            end
         end
      end
   endtask

   task automatic test_continuous();
      int vcyc[$];
      logic [15:0] vfrm[$];
      data = {4'd4, 4'd3, 4'd2, 4'd1};
      en = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         cycle();
         checks++;
         if (act4 !== expect_vec(DIV_A, m4)) begin
            errors++; $display("FAIL cont_model cyc%0d: got %h want %h", i, act4, expect_vec(DIV_A, m4));
         end
         if (fv4) begin vcyc.push_back(i); vfrm.push_back(frame4); end
         if (i == 17) data[3] = 4'd9;   // inside frame 2's ch0 window
      end
      en = 1'b0;
      cycle();
      checks++;
      if (vcyc.size() !== 2) begin
         errors++; $display("FAIL cont_pulse_count: got %0d want 2", vcyc.size());
      end else begin
         checks++;
         if ({vfrm[0], vfrm[1]} !== {16'h4321, 16'h9321}) begin
            errors++; $display("FAIL cont_frames: got %h %h want 4321 9321", vfrm[0], vfrm[1]);
         end
         checks++;
         if (vcyc[1] - vcyc[0] !== 4 * DIV_A) begin
            errors++; $display("FAIL cont_gap: got %0d want %0d", vcyc[1] - vcyc[0], 4 * DIV_A);
         end
      end
      checks++;
      if (busy4 !== 1'b0) begin
         errors++; $display("FAIL cont_stop: busy got %b want 0", busy4);
      end
   endtask

   task automatic test_abort();
      int pulses = 0;
      rst = 1'b1; cycle(); rst = 1'b0;
      en = 1'b1;
      repeat (10) cycle();
      en = 1'b0;
      cycle();
      checks++;
      if (act4 !== RESET_VEC) begin
         errors++; $display("FAIL abort_idle: got %h want %h", act4, RESET_VEC);
      end
      repeat (20) begin
         cycle();
         if (fv4) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++; $display("FAIL abort_no_pulse: got %0d want 0", pulses);
      end
   endtask

   task automatic test_priority();
      int vcyc[$];
      // en and start together: continuous wins, still busy after one frame.
      en = 1'b1; start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         start = 1'b0;
         checks++;
         if (act4 !== expect_vec(DIV_A, m4)) begin
            errors++; $display("FAIL prio_model cyc%0d: got %h want %h", i, act4, expect_vec(DIV_A, m4));
         end
      end
      checks++;
      if (busy4 !== 1'b1) begin
         errors++; $display("FAIL prio_cont: busy got %b want 1", busy4);
      end
      en = 1'b0;
      cycle();

      // Second start inside a single frame is ignored.
      start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         cycle();
         start = (i == 8);
         if (i >= 17) begin
            checks++;
            if ({busy4, fv4} !== {1'b0, (i == 17)}) begin
               errors++; $display("FAIL prio_restart cyc%0d: got busy=%b fv=%b want 0 %b", i, busy4, fv4, (i == 17));
            end
         end
      end

      // Held start: back-to-back frames, separated by the one IDLE cycle
      // between completion and the next accepted start.
      start = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         cycle();
         checks++;
         if (act4 !== expect_vec(DIV_A, m4)) begin
            errors++; $display("FAIL held_model cyc%0d: got %h want %h", i, act4, expect_vec(DIV_A, m4));
         end
         if (fv4) vcyc.push_back(i);
      end
      start = 1'b0;
      checks++;
      if (vcyc.size() !== 2) begin
         errors++; $display("FAIL held_pulse_count: got %0d want 2", vcyc.size());
      end else begin
         checks++;
         if (vcyc[1] - vcyc[0] !== 4 * DIV_A + 1) begin
            errors++; $display("FAIL held_gap: got %0d want %0d", vcyc[1] - vcyc[0], 4 * DIV_A + 1);
         end
      end
      repeat (20) cycle();
      checks++;
      if (busy4 !== 1'b0) begin
         errors++; $display("FAIL held_drain: busy got %b want 0", busy4);
      end
   endtask

   task automatic test_div2();
      rst = 1'b1; cycle(); rst = 1'b0;
      data = {4'hD, 4'hC, 4'hB, 4'hA};
      start = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         cycle();
         start = 1'b0;
         checks++;
         if (act2 !== expect_vec(DIV_B, m2)) begin
            errors++; $display("FAIL div2_model cyc%0d: got %h want %h", i, act2, expect_vec(DIV_B, m2));
         end
         if (i <= 8) begin
            checks++;
            if (sel2 !== 2'((i - 1) / 2)) begin
               errors++; $display("FAIL div2_sel cyc%0d: got %0d want %0d", i, sel2, (i - 1) / 2);
            end
         end
         if (i == 9) begin
            checks++;
            if ({fv2, busy2, frame2} !== {1'b1, 1'b0, 16'hDCBA}) begin
               errors++; $display("FAIL div2_publish: got fv=%b busy=%b frame=%h want 1 0 dcba", fv2, busy2, frame2);
            end
         end
      end
   endtask

   task automatic test_random();
      int pulses = 0;
      rst = 1'b0; en = 1'b0; start = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 19) == 0) en = ~en;
         start = ($urandom_range(0, 9) == 0);
         rst   = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 3) == 0) data = 16'($urandom);
         cycle();
         if (fv4) pulses++;
         checks++;
         if (act4 !== expect_vec(DIV_A, m4)) begin
            errors++; $display("FAIL rand_div4 cyc%0d: got %h want %h", i, act4, expect_vec(DIV_A, m4));
         end
         checks++;
         if (act2 !== expect_vec(DIV_B, m2)) begin
            errors++; $display("FAIL rand_div2 cyc%0d: got %h want %h", i, act2, expect_vec(DIV_B, m2));
         end
      end
      checks++;
      if (pulses == 0) begin
         errors++; $display("FAIL rand_activity: got 0 frames want >0");
      end
      rst = 1'b0; en = 1'b0; start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reset_mid_frame();
      test_single_frame();
      test_continuous();
      test_abort();
      test_priority();
      test_div2();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
